mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 19 +
 rtl/mem_arbiter_perf_cnt.sv | 19 +
 rtl/mem_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and default sizes for the fetch/data memory arbiter.
// The optional stall counter is enabled by defining MEM_ARBITER_PERF_EN.
package mem_arbiter_pkg;

  localparam int DEF_MEM_LAT = 2;
  localparam int DEF_DATA_W  = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arbiter_perf_cnt.sv
// Saturating 32-bit counter of stalled cycles.
// Only instantiated when MEM_ARBITER_PERF_EN is defined.
module mem_arbiter_perf_cnt (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inc_i,
  output logic [31:0] count_o
);

  // Holds at all-ones once reached so long runs never wrap to a small value
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_o <= '0;
    end else if (inc_i && (count_o != 32'hFFFF_FFFF)) begin
      count_o <= count_o + 32'd1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter shared by instruction fetch and data access; data wins.
// Define MEM_ARBITER_PERF_EN to add the perf_stall_cnt_o stall-cycle counter.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MEM_LAT = DEF_MEM_LAT,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              if_req_i,
  input  logic [DATA_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_valid_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [DATA_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_valid_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_o
`ifdef MEM_ARBITER_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt_o
`endif
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);

  state_t            state;
  owner_t            owner;
  logic              we_q;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] dm_rdata_q;

  // Counter is loaded with MEM_LAT-1 so the ACCESS cycle that sees zero is the last one
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      owner      <= OWN_IF;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i && (dm_req_i || if_req_i)) begin
            state <= ACCESS;
            cnt_q <= CNT_W'(MEM_LAT - 1);
            if (dm_req_i) begin
              owner   <= OWN_DM;
              we_q    <= dm_we_i;
              addr_q  <= dm_addr_i;
              wdata_q <= dm_wdata_i;
            end else begin
              owner   <= OWN_IF;
              we_q    <= 1'b0;
              addr_q  <= if_addr_i;
              wdata_q <= '0;
            end
          end
        end
        ACCESS: begin
          if (cnt_q == '0) begin
            state <= RESP;
            if (owner == OWN_IF) begin
              if_rdata_q <= mem_rdata_i;
            end else if (!we_q) begin
              dm_rdata_q <= mem_rdata_i;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign mem_en_o    = (state == ACCESS);
  assign mem_we_o    = mem_en_o & we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

  assign if_valid_o  = (state == RESP) && (owner == OWN_IF);
  assign dm_valid_o  = (state == RESP) && (owner == OWN_DM);
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;

  assign stall_o = (if_req_i & ~if_valid_o) | (dm_req_i & ~dm_valid_o);

`ifdef MEM_ARBITER_PERF_EN
  mem_arbiter_perf_cnt u_perf_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (stall_o),
    .count_o (perf_stall_cnt_o)
  );
`else
  // Default build carries no stall counter.
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios plus randomized traffic.
// Define MEM_ARBITER_PERF_EN to also check the stall counter.
module tb_mem_arbiter;

  localparam int MEM_LAT = 2;
  localparam int LAT     = MEM_LAT + 1;

  typedef struct packed {
    logic [31:0] data;
    int          cycle;
  } resp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } access_t;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic [31:0] if_rdata_o;
  logic        if_valid_o;
  logic        dm_req_i = 1'b0;
  logic        dm_we_i = 1'b0;
  logic [31:0] dm_addr_i = '0;
  logic [31:0] dm_wdata_i = '0;
  logic [31:0] dm_rdata_o;
  logic        dm_valid_o;
  logic        mem_en_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i = '0;
  logic        stall_o;
`ifdef MEM_ARBITER_PERF_EN
  logic [31:0] perf_stall_cnt_o;
`endif

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  resp_t   if_q[$];
  resp_t   dm_q[$];
  access_t acc_q[$];

  logic [31:0] env_mem[logic [31:0]];
  logic [31:0] shadow[logic [31:0]];
  logic [31:0] model_if = '0;
  logic [31:0] model_dm = '0;

  mem_arbiter #(.MEM_LAT(MEM_LAT), .DATA_W(32)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_rdata_o  (if_rdata_o),
    .if_valid_o  (if_valid_o),
    .dm_req_i    (dm_req_i),
    .dm_we_i     (dm_we_i),
    .dm_addr_i   (dm_addr_i),
    .dm_wdata_i  (dm_wdata_i),
    .dm_rdata_o  (dm_rdata_o),
    .dm_valid_o  (dm_valid_o),
    .mem_en_o    (mem_en_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .stall_o     (stall_o)
`ifdef MEM_ARBITER_PERF_EN
    ,
    .perf_stall_cnt_o (perf_stall_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Unwritten locations read back an address-dependent pattern
  function automatic logic [31:0] mem_default(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (shadow.exists(a)) return shadow[a];
    return mem_default(a);
  endfunction

  function automatic logic [31:0] env_read(input logic [31:0] a);
    if (env_mem.exists(a)) return env_mem[a];
    return mem_default(a);
  endfunction

  always @(negedge clk) mem_rdata_i = env_read(mem_addr_o);

  always @(posedge clk) begin
    if (mem_en_o && mem_we_o) env_mem[mem_addr_o] = mem_wdata_o;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a response or memory access
  logic prev_en = 1'b0;
  int   en_run = 0;
  always @(negedge clk) begin
    resp_t   r;
    access_t a;
    check_output("stall", {31'd0, stall_o},
                 {31'd0, (if_req_i && !if_valid_o) || (dm_req_i && !dm_valid_o)});
    if (if_valid_o) begin
      if (if_q.size() == 0) begin
        check_output("if_valid_unexpected", 32'd1, 32'd0);
      end else begin
        r = if_q.pop_front();
        check_output("if_rdata", if_rdata_o, r.data);
        check_output("if_valid_cycle", cyc, r.cycle);
      end
    end
    if (dm_valid_o) begin
      if (dm_q.size() == 0) begin
        check_output("dm_valid_unexpected", 32'd1, 32'd0);
      end else begin
        r = dm_q.pop_front();
        check_output("dm_rdata", dm_rdata_o, r.data);
        check_output("dm_valid_cycle", cyc, r.cycle);
      end
    end
    if (mem_en_o) begin
      en_run++;
      if (acc_q.size() == 0) begin
        check_output("mem_en_unexpected", 32'd1, 32'd0);
      end else begin
        a = acc_q[0];
        check_output("mem_addr", mem_addr_o, a.addr);
        check_output("mem_we", {31'd0, mem_we_o}, {31'd0, a.we});
        if (a.we) check_output("mem_wdata", mem_wdata_o, a.wdata);
      end
    end else if (prev_en) begin
      check_output("access_len", en_run, MEM_LAT);
      if (acc_q.size() != 0) void'(acc_q.pop_front());
      en_run = 0;
    end
    prev_en = mem_en_o;
  end

  // Reference model: DM is served first on a collision, IF follows after DM's response
  task automatic expect_txn(input bit do_if, input bit do_dm, input bit we,
                            input logic [31:0] ia, input logic [31:0] da,
                            input logic [31:0] wd, input int c0);
    int if_start;
    if (do_dm) begin
      acc_q.push_back('{addr: da, we: we, wdata: wd});
      if (we) shadow[da] = wd;
      else model_dm = model_read(da);
      dm_q.push_back('{data: model_dm, cycle: c0 + LAT});
    end
    if (do_if) begin
      if_start = do_dm ? c0 + LAT + 1 : c0;
      acc_q.push_back('{addr: ia, we: 1'b0, wdata: 32'd0});
      model_if = model_read(ia);
      if_q.push_back('{data: model_if, cycle: if_start + LAT});
    end
  endtask

  task automatic reset_dut();
    @(posedge clk); #1;
    rst_i = 1'b1; start_i = 1'b0; if_req_i = 1'b0; dm_req_i = 1'b0; dm_we_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0; start_i = 1'b1;
    if_q.delete(); dm_q.delete(); acc_q.delete();
    model_if = '0; model_dm = '0;
  endtask

  task automatic wait_done();
    int  budget = 4 * LAT + 10;
    bit  if_done, dm_done;
    while ((if_req_i || dm_req_i) && budget > 0) begin
      if_done = 1'b0; dm_done = 1'b0;
      @(negedge clk);
      if (if_valid_o) if_done = 1'b1;
      if (dm_valid_o) dm_done = 1'b1;
      @(posedge clk); #1;
      if (if_done) if_req_i = 1'b0;
      if (dm_done) begin dm_req_i = 1'b0; dm_we_i = 1'b0; end
      budget--;
    end
    if (if_req_i || dm_req_i) begin
      check_output("response_timeout", 32'd1, 32'd0);
      reset_dut();
    end
  endtask

  // Must be entered at the start of a cycle (just after a rising edge)
  task automatic apply_stimulus(input bit do_if, input bit do_dm, input bit we,
                                input logic [31:0] ia, input logic [31:0] da,
                                input logic [31:0] wd);
    start_i = 1'b1;
    if_req_i = do_if; if_addr_i = ia;
    dm_req_i = do_dm; dm_we_i = we; dm_addr_i = da; dm_wdata_i = wd;
    expect_txn(do_if, do_dm, we, ia, da, wd, cyc);
    wait_done();
  endtask

  logic [31:0] pool[8];

  initial begin
    reset_dut();
    @(negedge clk);
    check_output("rst_if_rdata", if_rdata_o, 32'd0);
    check_output("rst_dm_rdata", dm_rdata_o, 32'd0);
    check_output("rst_if_valid", {31'd0, if_valid_o}, 32'd0);
    check_output("rst_dm_valid", {31'd0, dm_valid_o}, 32'd0);
    check_output("rst_mem_en", {31'd0, mem_en_o}, 32'd0);
    check_output("rst_mem_we", {31'd0, mem_we_o}, 32'd0);
    check_output("rst_mem_addr", mem_addr_o, 32'd0);
    check_output("rst_mem_wdata", mem_wdata_o, 32'd0);
    @(posedge clk); #1;

    $display("[TB] fetch read");
    env_mem[32'h10] = 32'h0050_0093;
    shadow[32'h10]  = 32'h0050_0093;
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0);

    $display("[TB] collision");
    reset_dut();
    apply_stimulus(1'b1, 1'b1, 1'b0, 32'h10, 32'h40, 32'h0);
`ifdef MEM_ARBITER_PERF_EN
    @(negedge clk);
    check_output("perf_stall_cnt", perf_stall_cnt_o, 32'd7);
    @(posedge clk); #1;
`endif

    $display("[TB] store then load back");
    apply_stimulus(1'b0, 1'b1, 1'b1, 32'h0, 32'h20, 32'hDEAD_BEEF);
    apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0, 32'h20, 32'h0);

    $display("[TB] start held low");
    start_i = 1'b0; dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h44;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_output("start_low_mem_en", {31'd0, mem_en_o}, 32'd0);
      @(posedge clk); #1;
    end
    start_i = 1'b1;
    expect_txn(1'b0, 1'b1, 1'b0, 32'h0, 32'h44, 32'h0, cyc);
    wait_done();

    $display("[TB] reset during access");
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h40;
    expect_txn(1'b0, 1'b1, 1'b0, 32'h0, 32'h40, 32'h0, cyc);
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0; dm_req_i = 1'b0;
    dm_q.delete();
    model_if = '0; model_dm = '0;
    @(negedge clk);
    check_output("abort_mem_en", {31'd0, mem_en_o}, 32'd0);
    check_output("abort_dm_rdata", dm_rdata_o, 32'd0);
    check_output("abort_dm_valid", {31'd0, dm_valid_o}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_output("abort_dm_valid", {31'd0, dm_valid_o}, 32'd0);
      check_output("abort_if_valid", {31'd0, if_valid_o}, 32'd0);
    end
    @(posedge clk); #1;

    $display("[TB] randomized traffic");
    pool[0] = 32'h10; pool[1] = 32'h20; pool[2] = 32'h40; pool[3] = 32'h44;
    for (int i = 4; i < 8; i++) pool[i] = $urandom;
    for (int n = 0; n < 150; n++) begin
      int kind;
      int gap;
      gap = $urandom_range(0, 2);
      repeat (gap) begin @(posedge clk); #1; end
      kind = $urandom_range(0, 2);
      apply_stimulus(kind != 1, kind != 0, 1'($urandom_range(0, 1)),
                     pool[$urandom_range(0, 7)], pool[$urandom_range(0, 7)], $urandom);
    end

    repeat (3) @(posedge clk);
    #1;
    check_output("leftover_if_q", if_q.size(), 32'd0);
    check_output("leftover_dm_q", dm_q.size(), 32'd0);
    check_output("leftover_acc_q", acc_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
